// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM port controller: sequencing states and
// default macro geometry.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int DEF_BITS   = 32;
   localparam int DEF_DEPTH  = 64;
   localparam int DEF_ADDR_W = 6;

endpackage

// File: rtl/sram_resp_buf.sv
// One-entry holding buffer on the read response path. Read data comes
// straight from the macro Q pins on the cycle after the read; if the consumer
// stalls on that cycle, Q is captured here because the macro does not hold it.
module sram_resp_buf
   import sram_ctrl_pkg::*;
#(
   parameter int BITS = DEF_BITS
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic            rd_inflight,
   input  logic            resp_ready,
   input  logic [BITS-1:0] sram_q,
   output logic            buf_valid,
   output logic            resp_valid,
   output logic [BITS-1:0] resp_rdata
);

   logic [BITS-1:0] buf_data;

   // Capture Q on a stalled read; release the entry once the consumer takes it.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         buf_valid <= 1'b0;
         buf_data  <= '0;
      end else if (buf_valid) begin
         if (resp_ready) begin
            buf_valid <= 1'b0;
         end
      end else if (rd_inflight && !resp_ready) begin
         buf_valid <= 1'b1;
         buf_data  <= sram_q;
      end
   end

   // The buffered word takes priority; otherwise Q is passed through live.
   always_comb begin
      resp_valid = rd_inflight || buf_valid;
      resp_rdata = buf_valid ? buf_data : sram_q;
   end

endmodule

// File: rtl/sram_port_ctrl.sv
// Requester-side controller for a single-port SRAM macro (active-low CEB/WEB,
// one-cycle synchronous read). Zero-fills the array after reset, then maps a
// valid/ready request channel directly onto the macro pins and returns read
// data on a valid/ready response channel.
//
// state | meaning
// ------+----------------------------------------------------------
// BOOT  | one idle cycle after reset, macro deselected
// INIT  | zero-fill sweep, one write per cycle at address cnt
// RUN   | normal traffic, requests accepted when the response path can take them
module sram_port_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int BITS    = DEF_BITS,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter bit INIT_EN = 1'b1
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [BITS-1:0]   req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [BITS-1:0]   resp_rdata,
   output logic              init_done,
   output logic              sram_ceb,
   output logic              sram_web,
   output logic [ADDR_W-1:0] sram_a,
   output logic [BITS-1:0]   sram_d,
   input  logic [BITS-1:0]   sram_q
);

   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic              rd_inflight;
   logic              buf_valid;
   logic              fire;
   logic [ADDR_W-1:0] a_q;
   logic [BITS-1:0]   d_q;

   // A read still on Q with a stalled consumer would need a second buffer slot,
   // so the request side closes in that case and while the buffer is occupied.
   always_comb begin
      req_ready = (state == RUN) && !buf_valid && !(rd_inflight && !resp_ready);
      fire      = req_valid && req_ready;
      init_done = (state == RUN);
   end

   // Macro pins: sweep writes during INIT, pass-through of accepted requests in
   // RUN; address and data hold their last driven value when deselected.
   always_comb begin
      sram_ceb = 1'b1;
      sram_web = 1'b1;
      sram_a   = a_q;
      sram_d   = d_q;
      case (state)
         INIT: begin
            sram_ceb = 1'b0;
            sram_web = 1'b0;
            sram_a   = cnt;
            sram_d   = '0;
         end
         RUN: begin
            if (fire) begin
               sram_ceb = 1'b0;
               sram_web = !req_write;
               sram_a   = req_addr;
               sram_d   = req_wdata;
            end
         end
         default: begin
         end
      endcase
   end

   // Sequencing: BOOT -> (INIT sweep) -> RUN; cnt stops at the last address.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= BOOT;
         cnt   <= '0;
      end else begin
         case (state)
            BOOT: state <= INIT_EN ? INIT : RUN;
            INIT: begin
               if (cnt == CNT_LAST) begin
                  state <= RUN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN:     state <= RUN;
            default: state <= BOOT;
         endcase
      end
   end

   // Track the read whose data appears on Q next cycle, and hold the pins.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rd_inflight <= 1'b0;
         a_q         <= '0;
         d_q         <= '0;
      end else begin
         rd_inflight <= fire && !req_write;
         a_q         <= sram_a;
         d_q         <= sram_d;
      end
   end

   sram_resp_buf #(
      .BITS (BITS)
   ) u_resp_buf (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .rd_inflight (rd_inflight),
      .resp_ready  (resp_ready),
      .sram_q      (sram_q),
      .buf_valid   (buf_valid),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata)
   );

endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Requester-side controller for the single-port SRAM macros (active-low CEB/WEB, synchronous read with one-cycle Q latency, Q undefined on non-read cycles). It accepts a valid/ready request channel, drives the macro pins, and returns read data on a valid/ready response channel with a one-entry holding buffer. After reset it zero-fills the array before accepting traffic. It sits between cache/TLB array logic and each SRAM instance.

## Interface
- BITS, 32, data width; must match the macro.
- DEPTH, 64, word count; power of two.
- ADDR_W, 6, log2(DEPTH).
- INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = skip the sweep.

Ports:
- CLK  in  1  clock; single clock domain.
- RSTN  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid & ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  BITS  write data.
- resp_valid  out  1  read data valid.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  BITS  read data.
- init_done  out  1  high once RUN is reached.
- sram_ceb  out  1  macro CEB; active-low.
- sram_web  out  1  macro WEB; 0 = write.
- sram_a  out  ADDR_W  macro address.
- sram_d  out  BITS  macro write data.
- sram_q  in  BITS  macro read data; valid only on the cycle after a read.

## Operation
- States:
  - BOOT: reset state.
  - INIT: zero-fill sweep.
  - RUN: normal traffic.
- BOOT: one cycle with sram_ceb=1.
  - Goes to INIT if INIT_EN=1, else to RUN.
- INIT: counter cnt runs 0..DEPTH-1, one per cycle.
  - Drives sram_ceb=0, sram_web=0, sram_a=cnt, sram_d=0.
  - On cnt==DEPTH-1, goes to RUN.
  - req_ready=0 throughout.
- RUN:
  - req_ready = !buf_valid && !(rd_inflight && !resp_ready).
  - An accepted request (fire) drives the macro combinationally in the same cycle: sram_ceb=0, sram_web=!req_write, sram_a=req_addr, sram_d=req_wdata.
  - With no fire, sram_ceb=1, sram_web=1, sram_a and sram_d hold their last values.
- rd_inflight register: set on a read fire, cleared otherwise.
- Response path:
  - resp_valid = rd_inflight || buf_valid.
  - resp_rdata = buf_valid ? buf : sram_q.
  - If rd_inflight && !resp_ready, capture sram_q into buf and set buf_valid.
  - buf_valid clears on resp_ready.
- rd_inflight and buf_valid are never both 1, because req_ready=0 while buf_valid.
- Writes produce no response.
- Ordering is strict request order. Read followed by a write to the same address: the read returns the old data.
- Reset values:
  - state=BOOT, cnt=0, rd_inflight=0, buf_valid=0, buf=0.
  - Outputs: req_ready=0, resp_valid=0, init_done=0, sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
- Reset mid-operation: all of the above take effect asynchronously. An inflight read or buffered response is discarded and the sweep restarts.

## Timing
- Read latency: accepted at edge N, resp_valid high during cycle N+1.
  - With resp_ready=1: sustained one read per cycle.
- Backpressure:
  - Buffered response: one bubble after drain (req_ready returns the cycle after buf_valid clears).
  - req_ready depends combinationally on resp_ready.
- init_done and first req_ready: DEPTH+1 rising edges after RSTN release with INIT_EN=1; 1 edge with INIT_EN=0.
- cnt wraps only via the reset path; no wrap in RUN.

## Structure
- Package sram_ctrl_pkg: state enum (BOOT, INIT, RUN), default BITS/DEPTH constants.
- One natural sub-module: sram_resp_buf, the one-entry holding buffer with its valid/ready logic. All other logic is in the top.

## Test plan
- Reset release, INIT_EN=1 → 64 macro writes, addresses 0..63, D=0, sram_ceb=0 each cycle; init_done rises on edge 65; read addr 37 → 0x00000000.
- Write 0xDEADBEEF to addr 5, read addr 5 next cycle → resp_valid one cycle after the read fire, resp_rdata=0xDEADBEEF.
- Reads of addrs 0..7 back-to-back (preloaded data 0x100+addr), resp_ready=1 → eight responses on consecutive cycles, in order, sram_ceb low for 8 cycles.
- Read addr 1 (data 0xA1), resp_ready=0 for 3 cycles → buf holds 0xA1, req_ready=0, sram_ceb=1 during the stall; resp_ready=1 → 0xA1 delivered, req_ready high the following cycle.
- Assert RSTN low with rd_inflight=1 → resp_valid=0 and sram_ceb=1 immediately with no clock; release → full 64-write sweep repeats.
- INIT_EN=0 → init_done and req_ready high after 1 edge; no macro access before the first request.
